// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch front stage.
// Optional build macro IFU_PERF_COUNT_EN (used in ifu_fetch_stage) adds
// 64-bit performance counters; the types here are identical either way.
package ifu_pkg;

   // Address/instruction width; the stage only supports 32.
   localparam int IFU_XLEN = 32;

   // PC loaded on reset unless the top is given a different RESET_PC.
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

   // One-hot fetch FSM encoding.
   typedef enum logic [1:0] {
      ST_RUN  = 2'b01,  // lookup address may change every cycle
      ST_MISS = 2'b10   // cache refilling, lookup address frozen
   } fetch_state_t;

   // One fetched instruction as handed to decode.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_beat_t;

   // Instruction addresses are word aligned; low two bits are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_out_reg.sv
// Single-entry valid/ready output register between fetch and decode.
// Handshake: a beat moves when out_valid & out_ready are both high on a
// rising clock edge; while out_valid is high and the beat has not moved,
// out_pc/out_inst hold steady. flush drops a held beat unconditionally.
module ifu_out_reg
   import ifu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        slot_free
);

   fetch_beat_t beat_q;
   logic        valid_q;

   // Hold one beat; flush beats load, load beats drain.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q     <= 1'b1;
         beat_q.pc   <= in_pc;
         beat_q.inst <= in_inst;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign out_pc    = beat_q.pc;
   assign out_inst  = beat_q.inst;
   // The slot can take a new beat when empty or when the held one leaves now.
   assign slot_free = ~valid_q | out_ready;

endmodule

// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch front stage: owns the PC, drives the I-cache lookup
// address, turns cache hits into {pc, inst} beats for decode, and handles
// redirects and fence.i. The lookup address is frozen while the cache
// refills because the cache indexes its refill writes by the live address.
// Optional build macro IFU_PERF_COUNT_EN adds perf_fetch_cnt,
// perf_miss_cyc_cnt and perf_stall_cyc_cnt (64 bits each).
module ifu_fetch_stage
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          XLEN     = IFU_XLEN
)(
   input  logic            clock,
   input  logic            reset,
   output logic [XLEN-1:0] icache_addr,
   input  logic            icache_hit,
   input  logic [XLEN-1:0] icache_inst,
   output logic            icache_fencei,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            fencei_req,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst,
   output logic [1:0]      dbg_state
`ifdef IFU_PERF_COUNT_EN
   ,
   output logic [63:0]     perf_fetch_cnt,
   output logic [63:0]     perf_miss_cyc_cnt,
   output logic [63:0]     perf_stall_cyc_cnt
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            pend_valid_q, pend_valid_d;
   logic            fencei_q;
   logic            issue;
   logic            slot_free;

   // Fetch FSM, PC and pending-redirect registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         pend_pc_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // Registered fence.i: a one-cycle invalidate pulse the cycle after retire.
   always_ff @(posedge clock) begin
      if (reset) fencei_q <= 1'b0;
      else       fencei_q <= fencei_req;
   end

   // Next-state, next-PC and issue decision.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      issue        = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (redirect_valid) begin
               pc_d = align_pc(redirect_pc);
            end else if (fencei_q) begin
               // Hit is stale while the cache invalidates; wait a cycle.
               pc_d = pc_q;
            end else if (!icache_hit) begin
               state_d = ST_MISS;
            end else if (slot_free) begin
               issue = 1'b1;
               pc_d  = pc_q + 32'd4;
            end
         end
         ST_MISS: begin
            if (icache_hit) begin
               // The returning instruction is never issued from here; a
               // fresh lookup in ST_RUN delivers it (or the redirect target).
               state_d      = ST_RUN;
               pend_valid_d = 1'b0;
               if (redirect_valid)    pc_d = align_pc(redirect_pc);
               else if (pend_valid_q) pc_d = pend_pc_q;
            end else if (redirect_valid) begin
               pend_pc_d    = align_pc(redirect_pc);
               pend_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   ifu_out_reg u_out_reg (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect_valid),
      .load      (issue),
      .in_pc     (pc_q),
      .in_inst   (icache_inst),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .slot_free (slot_free)
   );

   assign icache_addr   = pc_q;
   assign icache_fencei = fencei_q;
   assign dbg_state     = state_q;

`ifdef IFU_PERF_COUNT_EN
   logic [63:0] fetch_cnt_q, miss_cnt_q, stall_cnt_q;

   // Beat, refill-cycle and back-pressure-cycle counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         miss_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (out_valid && out_ready)  fetch_cnt_q <= fetch_cnt_q + 64'd1;
         if (state_q == ST_MISS)      miss_cnt_q  <= miss_cnt_q + 64'd1;
         if ((state_q == ST_RUN) && out_valid && !out_ready)
            stall_cnt_q <= stall_cnt_q + 64'd1;
      end
   end

   assign perf_fetch_cnt     = fetch_cnt_q;
   assign perf_miss_cyc_cnt  = miss_cnt_q;
   assign perf_stall_cyc_cnt = stall_cnt_q;
`endif

endmodule
